rackbus_cin_aligner: RTL

Receive-side word aligner for the 6-bit rackbus link, the counterpart of the TURFIO rackbus transmitter that sends training pattern 011001 on CIN.
- Takes raw 6-bit parallel words from an ISERDES running on the divided clock.
- Finds the bit offset at which the training pattern appears, confirms lock, and delivers aligned words.
- Detects loss of alignment while training is asserted and re-hunts.

---
 rtl/rackbus_pkg.sv | 22 ++
 rtl/rackbus_word_shifter.sv | 41 ++++
 rtl/rackbus_cin_aligner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rackbus_pkg.sv
// rackbus_pkg: shared rackbus link definitions (word width, training word,
// aligner states), imported by both the transmitter and the receive aligner.
package rackbus_pkg;

    localparam int NBITS = 6;

    // All six rotations are distinct, so only one offset can ever match.
    localparam logic [NBITS-1:0] TRAIN_PATTERN = 6'b011001;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HUNT,
        CHECK,
        LOCKED
    } align_state_t;

    function automatic logic [2:0] next_offset(input logic [2:0] off);
        return (off == 3'd5) ? 3'd0 : off + 3'd1;
    endfunction

endpackage

// File: rtl/rackbus_word_shifter.sv
// rackbus_word_shifter: selects a 6-bit window out of {prev, current} raw
// ISERDES words by bit offset and registers the result.
module rackbus_word_shifter
    import rackbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] data_i,
    input  logic [2:0]       offset,
    output logic [NBITS-1:0] data_o
);

    logic [NBITS-1:0]   prev_q;
    logic [2*NBITS-1:0] cat;
    logic [NBITS-1:0]   aligned;

    assign cat = {prev_q, data_i};

    always_comb begin
        aligned = cat[5:0];
        unique case (offset)
            3'd1:    aligned = cat[6:1];
            3'd2:    aligned = cat[7:2];
            3'd3:    aligned = cat[8:3];
            3'd4:    aligned = cat[9:4];
            3'd5:    aligned = cat[10:5];
            default: aligned = cat[5:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            data_o <= '0;
        end else begin
            prev_q <= data_i;
            data_o <= aligned;
        end
    end

endmodule

// File: rtl/rackbus_cin_aligner.sv
// rackbus_cin_aligner: hunts the CIN training word, locks, and re-hunts on loss.
// Error/slip statistics are built only when RACKBUS_ALIGN_STATS_EN is defined.
module rackbus_cin_aligner
    import rackbus_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_MAX    = 4,
    parameter int SLIP_WAIT  = 2,
    parameter int HUNT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             train_i,
    input  logic [NBITS-1:0] data_i,
    output logic [NBITS-1:0] data_o,
    output logic             data_valid_o,
    output logic             locked_o,
    output logic [2:0]       offset_o,
    output logic             hunt_fail_o,
    output logic [15:0]      err_count_o
);

    localparam logic [8:0] LOCK_N = 9'(LOCK_COUNT);
    localparam logic [4:0] ERR_N  = 5'(ERR_MAX);
    localparam logic [2:0] WAIT_N = 3'(SLIP_WAIT);
    localparam logic [8:0] HUNT_N = 9'(HUNT_LIMIT);

    align_state_t state_q, state_d;
    logic [2:0]   offset_q, offset_d;
    logic [2:0]   wait_q, wait_d;
    logic [7:0]   match_q, match_d;
    logic [3:0]   err_q, err_d;
    logic [7:0]   sweep_q, sweep_d;
    logic         fail_q, fail_d;
    logic         advance;
    logic         match;
    logic [8:0]   match_inc;
    logic [4:0]   err_inc;
    logic [8:0]   sweep_inc;

    rackbus_word_shifter u_shifter (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .offset (offset_q),
        .data_o (data_o)
    );

    // Compared on the registered word, so a new offset needs one settle cycle.
    assign match     = (data_o == TRAIN_PATTERN);
    assign match_inc = {1'b0, match_q} + 9'd1;
    assign err_inc   = {1'b0, err_q} + 5'd1;
    assign sweep_inc = {1'b0, sweep_q} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            offset_q <= '0;
            wait_q   <= '0;
            match_q  <= '0;
            err_q    <= '0;
            sweep_q  <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            wait_q   <= wait_d;
            match_q  <= match_d;
            err_q    <= err_d;
            sweep_q  <= sweep_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        wait_d   = wait_q;
        match_d  = match_q;
        err_d    = err_q;
        sweep_d  = sweep_q;
        fail_d   = fail_q;
        advance  = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            sweep_d = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    wait_d  = WAIT_N;
                end
                WAIT: begin
                    wait_d = wait_q - 3'd1;
                    if (wait_q <= 3'd1) begin
                        state_d = HUNT;
                    end
                end
                HUNT: begin
                    if (match) begin
                        state_d = (LOCK_N <= 9'd1) ? LOCKED : CHECK;
                        match_d = 8'd1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                CHECK: begin
                    if (!match) begin
                        advance = 1'b1;
                    end else if (match_inc >= LOCK_N) begin
                        state_d = LOCKED;
                    end else begin
                        match_d = match_inc[7:0];
                    end
                end
                LOCKED: begin
                    // Without training traffic there is nothing to judge.
                    if (train_i) begin
                        if (match) begin
                            err_d = '0;
                        end else if (err_inc >= ERR_N) begin
                            advance = 1'b1;
                        end else begin
                            err_d = err_inc[3:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (advance) begin
                state_d  = WAIT;
                wait_d   = WAIT_N;
                err_d    = '0;
                offset_d = next_offset(offset_q);
                if (offset_q == 3'd5) begin
                    if (sweep_q != 8'hFF) begin
                        sweep_d = sweep_inc[7:0];
                    end
                    if (sweep_inc >= HUNT_N) begin
                        fail_d = 1'b1;
                    end
                end
            end

            if (state_d == LOCKED && state_q != LOCKED) begin
                sweep_d = '0;
                fail_d  = 1'b0;
                err_d   = '0;
            end
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign data_valid_o = (state_q == LOCKED);
    assign offset_o     = offset_q;
    assign hunt_fail_o  = fail_q;

`ifdef RACKBUS_ALIGN_STATS_EN
    logic        lock_err;
    logic        lock_loss;
    logic        slip;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_q;
    logic [7:0]  slip_cnt_q;

    assign lock_err  = enable_i && train_i && !match
                    && (state_q == LOCKED);
    assign lock_loss = lock_err && (err_inc >= ERR_N);
    assign slip      = (offset_d != offset_q);
    assign err_sum   = {1'b0, err_cnt_q} + {16'd0, lock_err}
                     + {16'd0, lock_loss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q  <= '0;
            slip_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (slip && slip_cnt_q != 8'hFF) begin
                slip_cnt_q <= slip_cnt_q + 8'd1;
            end
        end
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = 16'h0000;
`endif

endmodule
